// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART.
// Related build option: UART_PARITY_EN (selects the parity frame format in uart_param).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned CLKS_921600_AT_100M = 108;

  // Parity bit that makes the total ones count even (i_odd=0) or odd (i_odd=1).
  function automatic logic f_parity(input logic [7:0] i_data, input logic i_odd);
    return (^i_data) ^ i_odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: clears on load, wraps at the terminal count, flags the half period.
// Shared by the TX and RX paths of uart_param.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W = 9,
  parameter int unsigned HALF  = CLKS_921600_AT_100M / 2
) (
  input  logic             clk_100m,
  input  logic             rst,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_tc_c,
  output logic             o_half_c
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc_c   = (r_cnt == i_limit - CNT_W'(1));
  assign o_half_c = (r_cnt == CNT_W'(HALF));

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART with byte req/ack handshakes and a 2-flop RX synchroniser.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD parameter, rx_perr output).
module uart_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_921600_AT_100M,
  parameter int unsigned DATA_BITS    = 8,
`ifdef UART_PARITY_EN
  parameter int unsigned PARITY_ODD   = 0,
`endif
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk_100m,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_byte,
  input  logic                 tx_req,
  output logic                 tx_ack,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_req,
  input  logic                 rx_ack,
  output logic                 rx_ferr,
  output logic                 rx_ovr,
  input  logic                 rx,
`ifdef UART_PARITY_EN
  output logic                 rx_perr,
`endif
  output logic                 tx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT * 2) + 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  uart_state_e          r_tx_state;
  logic [DATA_BITS-1:0] r_tx_data;
  logic [IDX_W-1:0]     r_tx_idx;
  logic                 w_tx_clr;
  logic                 w_tx_tc;
  logic [CNT_W-1:0]     w_tx_limit;
  logic                 w_unused_tx_half;

  uart_state_e          r_rx_state;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [IDX_W-1:0]     r_rx_idx;
  logic                 r_rx_meta;
  logic                 r_rxs;
  logic                 w_rx_clr;
  logic                 w_rx_tc;
  logic                 w_rx_half;
  logic                 w_rx_load;
`ifdef UART_PARITY_EN
  logic                 r_tx_par;
  logic                 r_rx_par;
`endif

  assign w_tx_clr   = (r_tx_state == IDLE);
  assign w_tx_limit = (r_tx_state == STOP) ? CNT_W'(STOP_BITS * CLKS_PER_BIT)
                                           : CNT_W'(CLKS_PER_BIT);

  uart_bit_timer #(
    .CNT_W (CNT_W),
    .HALF  (CLKS_PER_BIT / 2)
  ) u_tx_timer (
    .clk_100m (clk_100m),
    .rst      (rst),
    .i_clr    (w_tx_clr),
    .i_limit  (w_tx_limit),
    .o_tc_c   (w_tx_tc),
    .o_half_c (w_unused_tx_half)
  );

  // TX: data shifts right so the next bit to send always sits in bit 1.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      r_tx_state <= IDLE;
      r_tx_data  <= '0;
      r_tx_idx   <= '0;
      tx         <= 1'b1;
      tx_ack     <= 1'b0;
      tx_busy    <= 1'b0;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      tx_ack <= 1'b0;
      case (r_tx_state)
        IDLE: begin
          if (tx_req) begin
            r_tx_data  <= tx_byte;
            tx_ack     <= 1'b1;
            tx_busy    <= 1'b1;
            tx         <= 1'b0;
            r_tx_state <= START;
`ifdef UART_PARITY_EN
            r_tx_par   <= f_parity(8'(tx_byte), PARITY_ODD != 0);
`endif
          end
        end
        START: begin
          if (w_tx_tc) begin
            tx         <= r_tx_data[0];
            r_tx_idx   <= '0;
            r_tx_state <= DATA;
          end
        end
        DATA: begin
          if (w_tx_tc) begin
            if (r_tx_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              tx         <= r_tx_par;
              r_tx_state <= PARITY;
`else
              tx         <= 1'b1;
              r_tx_state <= STOP;
`endif
            end else begin
              tx        <= r_tx_data[1];
              r_tx_data <= r_tx_data >> 1;
              r_tx_idx  <= r_tx_idx + IDX_W'(1);
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (w_tx_tc) begin
            tx         <= 1'b1;
            r_tx_state <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_tx_tc) begin
            tx_busy    <= 1'b0;
            r_tx_state <= IDLE;
          end
        end
        default: begin
          tx         <= 1'b1;
          tx_busy    <= 1'b0;
          r_tx_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  // Restarting the count at the mid-start sample puts every later sample mid-bit.
  assign w_rx_clr  = (r_rx_state == IDLE) || ((r_rx_state == START) && w_rx_half);
  assign w_rx_load = (r_rx_state == STOP) && w_rx_tc;

  uart_bit_timer #(
    .CNT_W (CNT_W),
    .HALF  (CLKS_PER_BIT / 2)
  ) u_rx_timer (
    .clk_100m (clk_100m),
    .rst      (rst),
    .i_clr    (w_rx_clr),
    .i_limit  (CNT_W'(CLKS_PER_BIT)),
    .o_tc_c   (w_rx_tc),
    .o_half_c (w_rx_half)
  );

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      r_rx_state <= IDLE;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      rx_byte    <= '0;
      rx_req     <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_ovr     <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par   <= 1'b0;
      rx_perr    <= 1'b0;
`endif
    end else begin
      case (r_rx_state)
        IDLE: begin
          if (!r_rxs) begin
            r_rx_state <= START;
          end
        end
        START: begin
          if (w_rx_half) begin
            r_rx_idx   <= '0;
            r_rx_state <= r_rxs ? IDLE : DATA;
          end
        end
        DATA: begin
          if (w_rx_tc) begin
            r_rx_shift <= {r_rxs, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              r_rx_state <= PARITY;
`else
              r_rx_state <= STOP;
`endif
            end else begin
              r_rx_idx <= r_rx_idx + IDX_W'(1);
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (w_rx_tc) begin
            r_rx_par   <= r_rxs;
            r_rx_state <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_rx_tc) begin
            r_rx_state <= IDLE;
          end
        end
        default: r_rx_state <= IDLE;
      endcase

      // A new byte load takes priority over a same-cycle acknowledge.
      if (w_rx_load) begin
        rx_byte <= r_rx_shift;
        rx_ferr <= ~r_rxs;
        rx_req  <= 1'b1;
        if (rx_req && !rx_ack) begin
          rx_ovr <= 1'b1;
        end
`ifdef UART_PARITY_EN
        rx_perr <= r_rx_par ^ f_parity(8'(r_rx_shift), PARITY_ODD != 0);
`endif
      end else if (rx_req && rx_ack) begin
        rx_req <= 1'b0;
        rx_ovr <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised full-duplex UART and successor to the fixed 921600-baud UART.
- Programmable bit period, data width and stop-bit count; 2-flop RX synchroniser; RX holding register with overrun and framing-error flags.
- Keeps the byte-level req/ack handshakes, so it drops into existing board-level designs between the host serial link and the processor I/O logic.

Parameters:
- CLKS_PER_BIT, 108, clk_100m cycles per UART bit (108 = 921600 baud at 100 MHz); legal range >= 4.
- DATA_BITS, 8, data bits per frame, legal 5..8, LSB first.
- STOP_BITS, 1, TX stop bits, legal 1 or 2. RX checks only the first stop bit.

Ports:
- clk_100m  in  1  system clock
- rst  in  1  asynchronous active-high reset
- tx_byte  in  DATA_BITS  byte to transmit
- tx_req  in  1  TX byte valid
- tx_ack  out  1  one-cycle pulse: tx_byte captured
- tx_busy  out  1  high from capture until the end of the last stop bit
- rx_byte  out  DATA_BITS  received byte (holding register)
- rx_req  out  1  rx_byte valid, held until acknowledged
- rx_ack  in  1  consumer has taken rx_byte
- rx_ferr  out  1  framing error for the byte in rx_byte
- rx_ovr  out  1  sticky overrun flag
- tx  out  1  serial out, idles high
- rx  in  1  serial in, asynchronous

Behaviour:
- Reset (async assert, sync release):
  - tx=1; tx_ack, tx_busy, rx_req, rx_ferr, rx_ovr = 0; rx_byte = 0.
  - Both FSMs go to IDLE; counters clear; synchroniser flops are set to 1.
  - Reset mid-frame aborts the frame; tx returns high immediately.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: when tx_req=1, capture tx_byte and pulse tx_ack for exactly 1 cycle. On the next edge tx=0 and tx_busy=1.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - DATA sends bits 0..DATA_BITS-1. STOP drives tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the end of STOP, tx_busy=0 and the FSM returns to IDLE. If tx_req is still high, a new capture happens on that IDLE cycle, so frames run back-to-back with a gap of 1 cycle.
  - tx_req is ignored while busy. The data source must drop tx_req, or present new data, after tx_ack.
- RX synchroniser: rx passes through 2 flops; all RX logic uses the synchronised signal rxs.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: when rxs=0, clear the counter and go to START.
  - START: sample at count CLKS_PER_BIT/2 (integer division). If rxs=1 it was a glitch: go to IDLE. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles into a shift register, LSB first, DATA_BITS samples.
  - STOP: sample once after CLKS_PER_BIT cycles. Then, in the same cycle:
    - rx_byte <= shift register; rx_ferr <= (stop sample == 0); rx_req <= 1.
    - If rx_req was already 1 and rx_ack is not asserted in this cycle, set rx_ovr=1. The new byte overwrites the old one.
    - Go to IDLE. No wait for the stop-bit end: this allows resynchronisation to a start bit that follows immediately.
- rx_ack:
  - rx_ack=1 while rx_req=1 clears rx_req on the next edge.
  - rx_ack in the same cycle as a new byte load: the load wins, rx_req stays 1, no overrun.
  - rx_ovr clears only on reset, or on rx_ack while rx_req=1 and no new load that cycle.
- The RX FSM never stalls on the handshake; reception continues while rx_req=1.
- Counters are sized $clog2(CLKS_PER_BIT*2)+1 bits; the bit index is sized $clog2(DATA_BITS+1).

Optional Feature:
- Macro UART_PARITY_EN. With it defined, a PARITY_ODD parameter (default 0) and an output rx_perr (1 bit, reset 0) are added.
- TX inserts a parity bit after the data bits: even parity by default, odd parity if PARITY_ODD=1.
- RX samples that bit as an extra bit period before STOP. rx_perr loads alongside rx_byte and is 1 on mismatch.
- Without the macro there is no parity state, no parity bit and no rx_perr port; framing is 1 + DATA_BITS + stop.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum: IDLE, START, DATA, PARITY, STOP;
  - the default-baud constant CLKS_921600_AT_100M = 108;
  - a parity function.
- One sub-module, uart_bit_timer: a counter with load and terminal-count and half-period outputs, instantiated once for TX and once for RX.
- The TX and RX FSMs stay in the top module.

Test Plan:
- Run all tests with CLKS_PER_BIT=8, DATA_BITS=8.
- TX single frame: tx_byte=0xA5 with a tx_req pulse -> tx_ack 1 cycle; tx low next cycle for 8 cycles, then bits 1,0,1,0,0,1,0,1 of 8 cycles each, then high; tx_busy for 80 cycles.
- TX back-to-back: tx_req held high with 0x00 then 0xFF -> second start bit exactly 1 cycle after the first stop bit ends.
- RX loopback (tx to rx): 0x3C -> rx_req=1, rx_byte=0x3C, rx_ferr=0; rx_ack clears rx_req next cycle.
- RX glitch and framing:
  - a 3-cycle low pulse on rx -> no rx_req;
  - 0x55 sent with the stop bit forced 0 -> rx_byte=0x55, rx_ferr=1.
- RX overrun: send 0x11 then 0x22 with no rx_ack -> rx_byte=0x22, rx_ovr=1; rx_ack then clears rx_req and rx_ovr.
- Async reset mid-TX frame: assert rst during bit 3 -> tx=1 and tx_busy=0 immediately; the next tx_req sends a full frame.
